lsu_rv32i: RTL and testbench

- Load/store unit sitting directly downstream of the RV32I decoder/execute stage.
- Consumes the decoded memory controls (is_store, mem_size, load signedness) plus the ALU-computed effective address and rs2 data.
- Drives a word-addressed data memory over a req/ack handshake, generating byte enables, lane-replicated store data and sign/zero-extended load results.
- Stalls the pipeline while a memory operation is in flight.

---
 rtl/lsu_rv32i.sv | 100 ++++++++++
 tb/tb_lsu_rv32i.sv | 119 +++++++++++
 2 files changed

// File: rtl/lsu_rv32i.sv
// lsu_rv32i: RV32I load/store unit driving a word-addressed req/ack data memory
module lsu_rv32i #(
  parameter int ADDR_W = 30
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_is_store,
  input  logic [3:0]        i_mem_size,
  input  logic              i_unsigned,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic              o_err,
  output logic [31:0]       o_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_n;
  logic lat_store, lat_h, lat_w, lat_u;
  logic [1:0] lat_a;
  logic legal;
  logic [3:0] be;
  logic [31:0] wd, lane, ld;
  // Decode the incoming request: legality, byte enables, replicated store data
  always_comb begin
    legal = (i_mem_size == 4'd1) || (i_mem_size == 4'd2 && !i_addr[0]) ||
            (i_mem_size == 4'd4 && i_addr[1:0] == 2'b00);
    be = i_mem_size == 4'd4 ? 4'b1111 :
         i_mem_size == 4'd2 ? (i_addr[1] ? 4'b1100 : 4'b0011) :
         4'b0001 << i_addr[1:0];
    wd = !i_is_store ? 32'h0 :
         i_mem_size == 4'd4 ? i_wdata :
         i_mem_size == 4'd2 ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
  end
  // Format the returned word: pick the lane, then sign- or zero-extend
  always_comb begin
    lane = i_mem_rdata >> {lat_a, 3'b000};
    ld = lat_w ? i_mem_rdata :
         lat_h ? {{16{~lat_u & lane[15]}}, lane[15:0]} :
         {{24{~lat_u & lane[7]}}, lane[7:0]};
  end
  // State register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_n;
  // Next-state logic; illegal accesses bypass memory straight to DONE
  always_comb begin
    state_n = state;
    if (state == IDLE && i_valid) state_n = legal ? REQ : DONE;
    else if (state == REQ && i_mem_ack) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  // Stall while accepting or waiting on memory; completion pulse in DONE
  always_comb begin
    o_stall = (state == IDLE && i_valid) || state == REQ;
    o_done = state == DONE;
  end
  // Latch the access at accept, hold memory outputs until ack, capture load data
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lat_store <= 1'b0;
      lat_h <= 1'b0;
      lat_w <= 1'b0;
      lat_u <= 1'b0;
      lat_a <= 2'b00;
      o_err <= 1'b0;
      o_rdata <= 32'h0;
      o_mem_req <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_addr <= '0;
      o_mem_be <= 4'h0;
      o_mem_wdata <= 32'h0;
    end else if (state == IDLE && i_valid) begin
      lat_store <= i_is_store;
      lat_h <= i_mem_size == 4'd2;
      lat_w <= i_mem_size == 4'd4;
      lat_u <= i_unsigned;
      lat_a <= i_addr[1:0];
      o_err <= !legal;
      o_rdata <= 32'h0;
      o_mem_req <= legal;
      o_mem_we <= legal & i_is_store;
      o_mem_addr <= legal ? i_addr[ADDR_W+1:2] : '0;
      o_mem_be <= legal ? be : 4'h0;
      o_mem_wdata <= legal ? wd : 32'h0;
    end else if (state == REQ && i_mem_ack) begin
      o_mem_req <= 1'b0;
      o_rdata <= lat_store ? 32'h0 : ld;
    end else if (state == DONE) begin
      o_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_rv32i.sv
// tb_lsu_rv32i: directed self-checking bench for lsu_rv32i
module tb_lsu_rv32i;
  logic i_clk = 0, i_rst = 1, i_valid = 0, i_is_store = 0, i_unsigned = 0, i_mem_ack = 0;
  logic [3:0] i_mem_size = 0;
  logic [31:0] i_addr = 0, i_wdata = 0, i_mem_rdata = 0;
  logic o_stall, o_done, o_err, o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [29:0] o_mem_addr;
  logic [3:0] o_mem_be;
  int total = 0, bad = 0;

  lsu_rv32i #(.ADDR_W(30)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_is_store(i_is_store),
    .i_mem_size(i_mem_size), .i_unsigned(i_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic op(input string tag, input logic st, input logic [3:0] sz, input logic un,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int dly,
                    input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd, input logic eerr);
    i_valid = 1; i_is_store = st; i_mem_size = sz; i_unsigned = un; i_addr = a; i_wdata = wd;
    #1 chk({tag, ".stall0"}, o_stall, 1);
    step();
    i_valid = 0; i_wdata = 32'hFFFF_FFFF;
    if (eerr) begin
      chk({tag, ".req"}, o_mem_req, 0);
      chk({tag, ".done"}, o_done, 1);
      chk({tag, ".err"}, o_err, 1);
      chk({tag, ".stall"}, o_stall, 0);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        chk({tag, ".req"}, o_mem_req, 1);
        chk({tag, ".we"}, o_mem_we, st);
        chk({tag, ".addr"}, {2'b00, o_mem_addr}, a >> 2);
        chk({tag, ".be"}, o_mem_be, ebe);
        chk({tag, ".wdata"}, o_mem_wdata, ewd);
        chk({tag, ".stall"}, o_stall, 1);
        chk({tag, ".nodone"}, o_done, 0);
        if (i == dly) begin
          i_mem_ack = 1; i_mem_rdata = rd;
        end
        step();
      end
      i_mem_ack = 0; i_mem_rdata = 32'h5A5A_5A5A;
      chk({tag, ".done"}, o_done, 1);
      chk({tag, ".err"}, o_err, 0);
      chk({tag, ".rdata"}, o_rdata, erd);
      chk({tag, ".reqoff"}, o_mem_req, 0);
      chk({tag, ".stalloff"}, o_stall, 0);
    end
    step();
    chk({tag, ".pulse"}, o_done, 0);
  endtask

  initial begin
    step();
    step();
    chk("rst.req", o_mem_req, 0);
    chk("rst.we", o_mem_we, 0);
    chk("rst.be", o_mem_be, 0);
    chk("rst.addr", {2'b00, o_mem_addr}, 0);
    chk("rst.wdata", o_mem_wdata, 0);
    chk("rst.done", o_done, 0);
    chk("rst.err", o_err, 0);
    chk("rst.rdata", o_rdata, 0);
    chk("rst.stall", o_stall, 0);
    i_rst = 0;
    step();
    chk("idle.stall", o_stall, 0);
    op("sb", 1, 1, 0, 32'h1003, 32'h0000_00A5, 32'hDEAD_BEEF, 0, 4'b1000, 32'hA5A5_A5A5, 0, 0);
    op("lh", 0, 2, 0, 32'h0002, 0, 32'h8001_1234, 3, 4'b1100, 0, 32'hFFFF_8001, 0);
    op("lbu", 0, 1, 1, 32'h0001, 0, 32'h0000_F000, 0, 4'b0010, 0, 32'h0000_00F0, 0);
    op("lb", 0, 1, 0, 32'h0001, 0, 32'h0000_F000, 0, 4'b0010, 0, 32'hFFFF_FFF0, 0);
    op("lwmis", 0, 4, 0, 32'h0006, 0, 0, 0, 0, 0, 0, 1);
    op("sw", 1, 4, 0, 32'h0010, 32'h1234_5678, 0, 1, 4'b1111, 32'h1234_5678, 0, 0);
    op("sh", 1, 2, 0, 32'h0002, 32'hABCD_1234, 0, 0, 4'b1100, 32'h1234_1234, 0, 0);
    op("lhu", 0, 2, 1, 32'h0000, 0, 32'h0000_8001, 2, 4'b0011, 0, 32'h0000_8001, 0);
    op("lbpos", 0, 1, 0, 32'h0002, 0, 32'h007F_0000, 0, 4'b0100, 0, 32'h0000_007F, 0);
    op("shmis", 1, 2, 0, 32'h0001, 32'h1, 0, 0, 0, 0, 0, 1);
    op("size3", 0, 3, 0, 32'h0000, 0, 0, 0, 0, 0, 0, 1);
    i_mem_ack = 1;
    step();
    i_mem_ack = 0;
    chk("idleack.done", o_done, 0);
    chk("idleack.req", o_mem_req, 0);
    i_valid = 1; i_is_store = 0; i_mem_size = 4; i_addr = 32'h20;
    step();
    i_valid = 0;
    chk("midrst.req", o_mem_req, 1);
    i_rst = 1;
    step();
    i_rst = 0;
    chk("midrst.reqoff", o_mem_req, 0);
    chk("midrst.stall", o_stall, 0);
    chk("midrst.done", o_done, 0);
    step();
    chk("midrst.done2", o_done, 0);
    op("lw", 0, 4, 0, 32'h0024, 0, 32'hCAFE_F00D, 0, 4'b1111, 0, 32'hCAFE_F00D, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
